// File: rtl/grey_gain_adjust.sv
// Camera-path grey/equalise stage: optional weighted-luma grey, runtime gain/offset
// with saturation, stepped from a debounced pushbutton. Fixed 3-cycle pipeline.
module grey_gain_adjust #(
  parameter int DW      = 12,
  parameter int KW      = 8,
  parameter int FRAC    = 4,
  parameter int CW      = 8,
  parameter int DEB_CNT = 50000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iDVAL,
  input  logic [DW-1:0]      iRed,
  input  logic [DW-1:0]      iGreen,
  input  logic [DW-1:0]      iBlue,
  input  logic               iGREY_EN,
  input  logic               iEQ_EN,
  input  logic               iKEY_N,
  input  logic               iINC,
  input  logic               iSEL_C,
  output logic               oDVAL,
  output logic [DW-1:0]      oRed,
  output logic [DW-1:0]      oGreen,
  output logic [DW-1:0]      oBlue,
  output logic [KW+CW-1:0]   oK_reading
);

  localparam int CNTW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            key_db_q, key_db_d, key_prev_q, key_prev_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   gain_q, gain_d;
  logic [CW-1:0]   off_q, off_d;
  logic            press;

  logic            s1_dval_q, s1_dval_d, s1_grey_q, s1_grey_d;
  logic [DW-1:0]   s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d, s1_y_q, s1_y_d;
  logic [KW-1:0]   s1_gain_q, s1_gain_d;
  logic [CW-1:0]   s1_off_q, s1_off_d;

  logic            s2_dval_q, s2_dval_d, s2_grey_q, s2_grey_d;
  logic [DW-1:0]   s2_r_q, s2_r_d, s2_g_q, s2_g_d, s2_b_q, s2_b_d;
  logic [DW+KW-1:0] s2_p_q, s2_p_d;
  logic [CW-1:0]   s2_off_q, s2_off_d;

  logic            s3_dval_q, s3_dval_d;
  logic [DW-1:0]   s3_r_q, s3_r_d, s3_g_q, s3_g_d, s3_b_q, s3_b_d;

  logic [DW+7:0]   y_sum;
  logic [DW+KW-1:0] prod;
  logic [DW+KW:0]  v_sum;
  logic [DW-1:0]   v_sat;

  always_comb begin
    sync1_d    = iKEY_N;
    sync2_d    = sync1_q;
    key_db_d   = key_db_q;
    key_prev_d = key_db_q;
    cnt_d      = '0;
    // Count only while the synced level disagrees with the accepted level.
    if (sync2_q != key_db_q) begin
      if (cnt_q == CNTW'(DEB_CNT - 1)) key_db_d = sync2_q;
      else                             cnt_d    = cnt_q + 1'b1;
    end
    press = key_prev_q & ~key_db_q;

    gain_d = gain_q;
    off_d  = off_q;
    if (press && iEQ_EN) begin
      if (!iSEL_C) begin
        if (iINC) begin
          if (gain_q != '1) gain_d = gain_q + 1'b1;
        end else if (gain_q != '0) gain_d = gain_q - 1'b1;
      end else begin
        if (iINC) begin
          if (off_q != '1) off_d = off_q + 1'b1;
        end else if (off_q != '0) off_d = off_q - 1'b1;
      end
    end

    y_sum = (DW+8)'(iRed) * (DW+8)'(77) + (DW+8)'(iGreen) * (DW+8)'(150)
          + (DW+8)'(iBlue) * (DW+8)'(29);
    s1_dval_d = iDVAL;
    s1_grey_d = iGREY_EN;
    s1_r_d    = iRed;
    s1_g_d    = iGreen;
    s1_b_d    = iBlue;
    s1_y_d    = DW'(y_sum >> 8);
    s1_gain_d = gain_q;
    s1_off_d  = off_q;

    prod      = (DW+KW)'(s1_y_q) * (DW+KW)'(s1_gain_q);
    s2_dval_d = s1_dval_q;
    s2_grey_d = s1_grey_q;
    s2_r_d    = s1_r_q;
    s2_g_d    = s1_g_q;
    s2_b_d    = s1_b_q;
    s2_p_d    = prod >> FRAC;
    s2_off_d  = s1_off_q;

    v_sum = (DW+KW+1)'(s2_p_q) + ((DW+KW+1)'(s2_off_q) << (DW - CW));
    v_sat = (v_sum[DW+KW:DW] != '0) ? '1 : v_sum[DW-1:0];
    s3_dval_d = s2_dval_q;
    s3_r_d    = s2_grey_q ? v_sat : s2_r_q;
    s3_g_d    = s2_grey_q ? v_sat : s2_g_q;
    s3_b_d    = s2_grey_q ? v_sat : s2_b_q;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync1_q <= 1'b1;  sync2_q <= 1'b1;
      key_db_q <= 1'b1; key_prev_q <= 1'b1;
      cnt_q <= '0;
      gain_q <= KW'(1 << FRAC);
      off_q <= '0;
      s1_dval_q <= 1'b0; s1_grey_q <= 1'b0;
      s1_r_q <= '0; s1_g_q <= '0; s1_b_q <= '0; s1_y_q <= '0;
      s1_gain_q <= '0; s1_off_q <= '0;
      s2_dval_q <= 1'b0; s2_grey_q <= 1'b0;
      s2_r_q <= '0; s2_g_q <= '0; s2_b_q <= '0; s2_p_q <= '0; s2_off_q <= '0;
      s3_dval_q <= 1'b0;
      s3_r_q <= '0; s3_g_q <= '0; s3_b_q <= '0;
    end else begin
      sync1_q <= sync1_d;  sync2_q <= sync2_d;
      key_db_q <= key_db_d; key_prev_q <= key_prev_d;
      cnt_q <= cnt_d;
      gain_q <= gain_d;
      off_q <= off_d;
      s1_dval_q <= s1_dval_d; s1_grey_q <= s1_grey_d;
      s1_r_q <= s1_r_d; s1_g_q <= s1_g_d; s1_b_q <= s1_b_d; s1_y_q <= s1_y_d;
      s1_gain_q <= s1_gain_d; s1_off_q <= s1_off_d;
      s2_dval_q <= s2_dval_d; s2_grey_q <= s2_grey_d;
      s2_r_q <= s2_r_d; s2_g_q <= s2_g_d; s2_b_q <= s2_b_d; s2_p_q <= s2_p_d;
      s2_off_q <= s2_off_d;
      s3_dval_q <= s3_dval_d;
      s3_r_q <= s3_r_d; s3_g_q <= s3_g_d; s3_b_q <= s3_b_d;
    end
  end

  assign oDVAL      = s3_dval_q;
  assign oRed       = s3_r_q;
  assign oGreen     = s3_g_q;
  assign oBlue      = s3_b_q;
  assign oK_reading = {gain_q, off_q};

endmodule

// File: tb/tb_grey_gain_adjust.sv
// Self-checking bench for grey_gain_adjust: arithmetic reference model with a
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_grey_gain_adjust;
  localparam int DW = 12, KW = 8, FRAC = 4, CW = 8, DEB = 4;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, dval = 1'b0, grey = 1'b0;
  logic eq = 1'b0, key_n = 1'b1, inc = 1'b0, sel = 1'b0;
  logic [DW-1:0] r = '0, g = '0, b = '0;
  logic o_dval;
  logic [DW-1:0] o_r, o_g, o_b;
  logic [KW+CW-1:0] o_k;

  int checks = 0, failures = 0;
  int m_gain = 1 << FRAC, m_off = 0;
  bit busy = 1'b1;

  typedef struct { bit v; int r; int g; int b; } pix_t;
  pix_t q[$];

  grey_gain_adjust #(.DW(DW), .KW(KW), .FRAC(FRAC), .CW(CW), .DEB_CNT(DEB)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDVAL(dval), .iRed(r), .iGreen(g), .iBlue(b),
    .iGREY_EN(grey), .iEQ_EN(eq), .iKEY_N(key_n), .iINC(inc), .iSEL_C(sel),
    .oDVAL(o_dval), .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oK_reading(o_k));

  always #5 clk = ~clk;

  function automatic pix_t model(bit v, bit gy, int rr, int gg, int bb, int gain, int off);
    pix_t e;
    int y;
    longint val;
    e.v = v;
    if (!gy) begin
      e.r = rr; e.g = gg; e.b = bb;
    end else begin
      y   = (77 * rr + 150 * gg + 29 * bb) / 256;
      val = (longint'(y) * gain) / (1 << FRAC) + longint'(off) * (1 << (DW - CW));
      if (val > MAXV) val = MAXV;
      e.r = int'(val); e.g = int'(val); e.b = int'(val);
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      repeat (3) q.push_back('{v: 1'b0, r: 0, g: 0, b: 0});
    end else if (q.size() > 0) begin
      q.push_back(model(dval, grey, int'(r), int'(g), int'(b), m_gain, m_off));
      if (q.size() > 3) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [15:0] k_exp;
    if (q.size() == 3) begin
      chk("cmp_dval", 32'(o_dval), 32'(q[0].v));
      if (q[0].v) begin
        chk("cmp_red", 32'(o_r), 32'(q[0].r));
        chk("cmp_green", 32'(o_g), 32'(q[0].g));
        chk("cmp_blue", 32'(o_b), 32'(q[0].b));
      end
      if (!busy) begin
        k_exp = {m_gain[7:0], m_off[7:0]};
        chk("cmp_k", 32'(o_k), 32'(k_exp));
      end
    end
  end

  task automatic do_reset(int n, bit check_now);
    busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; dval = 1'b0; key_n = 1'b1;
    m_gain = 1 << FRAC; m_off = 0;
    repeat (n) @(negedge clk);
    if (check_now) begin
      chk("rst_k", 32'(o_k), 32'h1000);
      chk("rst_dval", 32'(o_dval), 32'h0);
      chk("rst_red", 32'(o_r), 32'h0);
      chk("rst_green", 32'(o_g), 32'h0);
      chk("rst_blue", 32'(o_b), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic press_key(int len, bit e, bit i, bit s);
    busy = 1'b1;
    dval = 1'b0;
    @(negedge clk);
    eq = e; inc = i; sel = s; key_n = 1'b0;
    repeat (len) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    if (len >= DEB && e) begin
      if (!s) m_gain = i ? ((m_gain < (1 << KW) - 1) ? m_gain + 1 : m_gain)
                         : ((m_gain > 0) ? m_gain - 1 : 0);
      else    m_off  = i ? ((m_off < (1 << CW) - 1) ? m_off + 1 : m_off)
                         : ((m_off > 0) ? m_off - 1 : 0);
    end
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic pix(bit gy, int rr, int gg, int bb, int ex, string nm);
    dval = 1'b0;
    repeat (3) @(negedge clk);
    grey = gy; r = DW'(rr); g = DW'(gg); b = DW'(bb); dval = 1'b1;
    @(negedge clk);
    dval = 1'b0;
    chk({nm, "_idle1"}, 32'(o_dval), 32'h0);
    @(negedge clk);
    chk({nm, "_idle2"}, 32'(o_dval), 32'h0);
    @(negedge clk);
    chk({nm, "_dval"}, 32'(o_dval), 32'h1);
    chk({nm, "_red"}, 32'(o_r), gy ? 32'(ex) : 32'(rr));
    chk({nm, "_green"}, 32'(o_g), gy ? 32'(ex) : 32'(gg));
    chk({nm, "_blue"}, 32'(o_b), gy ? 32'(ex) : 32'(bb));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset(2, 1'b1);

    pix(1'b0, 'h123, 'h456, 'h789, 0, "bypass");
    pix(1'b1, 'h800, 'h800, 'h800, 'h800, "grey_mid");
    pix(1'b1, 'hFFF, 'hFFF, 'hFFF, 'hFFF, "grey_max");
    pix(1'b1, 'hFFF, 0, 0, 'h4CF, "grey_red");

    press_key(3, 1'b1, 1'b1, 1'b0);
    press_key(2, 1'b1, 1'b1, 1'b1);
    press_key(10, 1'b0, 1'b1, 1'b0);
    chk("deb_en_k", 32'(o_k), 32'h1000);
    press_key(10, 1'b1, 1'b1, 1'b0);
    chk("one_step_k", 32'(o_k), 32'h1100);
    press_key(10, 1'b1, 1'b0, 1'b0);

    repeat (16) press_key(10, 1'b1, 1'b1, 1'b0);
    chk("gain16_k", 32'(o_k), 32'h2000);
    pix(1'b1, 'h800, 'h800, 'h800, 'hFFF, "gain_clamp");
    repeat (223) press_key(10, 1'b1, 1'b1, 1'b0);
    chk("gain_max_k", 32'(o_k), 32'hFF00);
    press_key(10, 1'b1, 1'b1, 1'b0);
    chk("gain_hold_k", 32'(o_k), 32'hFF00);

    do_reset(1, 1'b0);
    repeat (3) press_key(10, 1'b1, 1'b1, 1'b1);
    chk("off3_k", 32'(o_k), 32'h1003);
    pix(1'b1, 'h800, 'h800, 'h800, 'h830, "offset");
    repeat (4) press_key(10, 1'b1, 1'b0, 1'b1);
    chk("off_floor_k", 32'(o_k), 32'h1000);

    repeat (16) press_key(10, 1'b1, 1'b1, 1'b0);
    repeat (5) press_key(10, 1'b1, 1'b1, 1'b1);
    chk("midop_k", 32'(o_k), 32'h2005);
    @(negedge clk);
    grey = 1'b1; dval = 1'b1; r = 'h400; g = 'h200; b = 'h100;
    repeat (2) @(negedge clk);
    do_reset(1, 1'b1);

    for (int round = 0; round < 10; round++) begin
      repeat ($urandom_range(1, 8))
        press_key(($urandom % 4 == 0) ? 3 : 10, ($urandom % 5) != 0,
                  ($urandom % 3) != 0, $urandom % 2);
      repeat (60) begin
        @(negedge clk);
        dval = $urandom % 2; grey = $urandom % 2;
        r = DW'($urandom); g = DW'($urandom); b = DW'($urandom);
      end
      @(negedge clk);
      dval = 1'b0;
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
